// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Purpose:
//   Cascaded BCD up/down counter of DIGITS decimal digits. Each enabled
//   cycle moves the count by one in the direction selected by dec. At the
//   ends of the range it either wraps (SATURATE=0) or holds (SATURATE=1).
//   The counter also supports a synchronous parallel load. Illegal BCD digits
//   (10..15) in load_val are loaded as 0, so value only ever holds 0..9 per
//   digit.
//
// Parameters:
//   DIGITS     - number of BCD digits, 1..8
//   SATURATE   - 0: wrap at range ends, 1: hold at range ends
//
// Ports:
//   clk        - in  : clock, all state changes on its rising edge
//   reset      - in  : synchronous active-high reset, clears value
//   en         - in  : count enable, one step per cycle while high
//   dec        - in  : step direction, 0 = up, 1 = down
//   load       - in  : synchronous parallel load strobe (beats en)
//   load_val   - in  : BCD value to load, digit i at [4i+3:4i]
//   value      - out : registered BCD count, same packing as load_val
//   carry_out  - out : combinational, stepping up from all 9s this cycle
//   borrow_out - out : combinational, stepping down from all 0s this cycle
//   at_zero    - out : combinational, value is all zeros
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  at_zero
);

  logic [4*DIGITS-1:0] load_clean;
  logic [4*DIGITS-1:0] step_val;
  logic                all_nine;
  logic                all_zero;
  logic                at_end;

  // Sanitise the load value digit by digit. Any pattern above 9 becomes 0,
  // so the registers can never pick up a non-BCD digit.
  always_comb begin
    load_clean = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] <= 4'd9) begin
        load_clean[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  // Detect the two range ends. These flags drive the cascade outputs, the
  // zero flag, and the saturation hold.
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (value[4*i +: 4] != 4'd0) all_zero = 1'b0;
    end
  end

  // Ripple the step through the digits. Digit 0 always steps. Each higher
  // digit steps only while every lower digit was sitting at its rollover
  // value: 9 when counting up, 0 when counting down.
  always_comb begin
    logic       ripple;
    logic [3:0] d;
    step_val = value;
    ripple   = 1'b1;
    d        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = value[4*i +: 4];
      if (ripple) begin
        if (dec) step_val[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
        else     step_val[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
      end
      ripple = ripple & (dec ? (d == 4'd0) : (d == 4'd9));
    end
  end

  // The cascade outputs flag a step that leaves the range. Reset and load
  // both suppress the step, so they also suppress these flags.
  always_comb begin
    carry_out  = en & ~dec & ~load & ~reset & all_nine;
    borrow_out = en &  dec & ~load & ~reset & all_zero;
    at_end     = dec ? all_zero : all_nine;
    at_zero    = all_zero;
  end

  // Digit registers, priority reset > load > en. In saturating mode a step
  // that would leave the range is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_clean;
    end else if (en && !(SATURATE && at_end)) begin
      value <= step_val;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Purpose:
//   Self-checking bench for bcd_updown_counter. It builds three instances:
//   a: DIGITS=2 wrapping, b: DIGITS=2 saturating, c: DIGITS=4 wrapping.
//   An integer model predicts every step. Expected register values are
//   queued when stimulus is driven and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  typedef struct {
    int          k;
    logic [15:0] v;
    logic        z;
  } exp_t;

  logic        clk;
  logic        reset_a, en_a, dec_a, load_a;
  logic        reset_b, en_b, dec_b, load_b;
  logic        reset_c, en_c, dec_c, load_c;
  logic [7:0]  load_val_a, load_val_b, value_a, value_b;
  logic [15:0] load_val_c, value_c;
  logic        carry_a, borrow_a, zero_a;
  logic        carry_b, borrow_b, zero_b;
  logic        carry_c, borrow_c, zero_c;

  int   n_checks;
  int   n_fails;
  int   model_val [3];
  int   num_digits [3] = '{2, 2, 4};
  bit   saturating [3] = '{1'b0, 1'b1, 1'b0};
  exp_t scoreboard [$];

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .dec(dec_a), .load(load_a),
    .load_val(load_val_a), .value(value_a), .carry_out(carry_a),
    .borrow_out(borrow_a), .at_zero(zero_a)
  );

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .dec(dec_b), .load(load_b),
    .load_val(load_val_b), .value(value_b), .carry_out(carry_b),
    .borrow_out(borrow_b), .at_zero(zero_b)
  );

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_c (
    .clk(clk), .reset(reset_c), .en(en_c), .dec(dec_c), .load(load_c),
    .load_val(load_val_c), .value(value_c), .carry_out(carry_c),
    .borrow_out(borrow_c), .at_zero(zero_c)
  );

  // Free-running clock with a 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the run ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when the values differ
  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int bcdToInt(input logic [15:0] v, input int nd);
    int r = 0;
    int w = 1;
    for (int i = 0; i < nd; i++) begin
      logic [3:0] d;
      d = v[4*i +: 4];
      if (d > 4'd9) d = 4'd0;
      r += int'(d) * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] intToBcd(input int x, input int nd);
    logic [15:0] r = '0;
    int          t = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'((t % 10));
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] getValue(input int k);
    case (k)
      0:       return {8'h00, value_a};
      1:       return {8'h00, value_b};
      default: return value_c;
    endcase
  endfunction

  function automatic logic [2:0] getFlags(input int k);
    case (k)
      0:       return {carry_a, borrow_a, zero_a};
      1:       return {carry_b, borrow_b, zero_b};
      default: return {carry_c, borrow_c, zero_c};
    endcase
  endfunction

  // Drives one cycle on instance k and leaves the others idle. It checks the
  // cascade flags before the edge, queues the predicted register value, then
  // pops and compares the value after the edge.
  task automatic applyStimulus(input int k, input bit r, input bit l,
                               input logic [15:0] lv, input bit e,
                               input bit d);
    int          maxv;
    bit          exp_c, exp_b;
    logic [2:0]  flags;
    exp_t        item;
    exp_t        got_item;
    @(negedge clk);
    {reset_a, load_a, en_a, dec_a} = 4'b0;
    {reset_b, load_b, en_b, dec_b} = 4'b0;
    {reset_c, load_c, en_c, dec_c} = 4'b0;
    case (k)
      0: begin reset_a = r; load_a = l; en_a = e; dec_a = d; load_val_a = lv[7:0]; end
      1: begin reset_b = r; load_b = l; en_b = e; dec_b = d; load_val_b = lv[7:0]; end
      default: begin reset_c = r; load_c = l; en_c = e; dec_c = d; load_val_c = lv; end
    endcase
    #1;
    maxv  = (num_digits[k] == 4) ? 9999 : 99;
    exp_c = e && !d && !l && !r && (model_val[k] == maxv);
    exp_b = e && d && !l && !r && (model_val[k] == 0);
    flags = getFlags(k);
    checkOutput($sformatf("carry_out[%0d]", k), {15'h0, flags[2]}, {15'h0, exp_c});
    checkOutput($sformatf("borrow_out[%0d]", k), {15'h0, flags[1]}, {15'h0, exp_b});

    if (r) begin
      model_val[k] = 0;
    end else if (l) begin
      model_val[k] = bcdToInt(lv, num_digits[k]);
    end else if (e) begin
      if (!d) begin
        if (model_val[k] == maxv) model_val[k] = saturating[k] ? maxv : 0;
        else                      model_val[k] = model_val[k] + 1;
      end else begin
        if (model_val[k] == 0) model_val[k] = saturating[k] ? 0 : maxv;
        else                   model_val[k] = model_val[k] - 1;
      end
    end
    item.k = k;
    item.v = intToBcd(model_val[k], num_digits[k]);
    item.z = (model_val[k] == 0);
    scoreboard.push_back(item);

    @(posedge clk);
    #1;
    got_item = scoreboard.pop_front();
    flags    = getFlags(got_item.k);
    checkOutput($sformatf("value[%0d]", got_item.k), getValue(got_item.k), got_item.v);
    checkOutput($sformatf("at_zero[%0d]", got_item.k), {15'h0, flags[0]}, {15'h0, got_item.z});
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 3; i++) model_val[i] = 0;
    {reset_a, load_a, en_a, dec_a} = 4'b0;
    {reset_b, load_b, en_b, dec_b} = 4'b0;
    {reset_c, load_c, en_c, dec_c} = 4'b0;
    load_val_a = '0;
    load_val_b = '0;
    load_val_c = '0;

    // Reset every instance
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    // Full up-count through 99 and the wrap back to 00
    for (int i = 0; i < 100; i++) applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Load 40, then count down across the digit boundary
    applyStimulus(0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Change direction on consecutive cycles, and hold with en low
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    // An illegal digit is loaded as 0, and en is ignored during the load
    applyStimulus(0, 1'b0, 1'b1, 16'h00A7, 1'b1, 1'b0);

    // Reset beats a same-cycle load and step at 57
    applyStimulus(0, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 16'h0012, 1'b1, 1'b0);

    // Wrap from 00 down to 99
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Saturating instance holds at both ends
    applyStimulus(1, 1'b0, 1'b1, 16'h0099, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Four-digit ripple across several digits in both directions
    applyStimulus(2, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b1, 16'hF9C3, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    checkOutput("scoreboard_empty", 16'(scoreboard.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
